// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: pops characters from a first-word-fall-through FIFO
// and serialises them as start / data (LSB first) / optional parity / stop bits.
module uart_tx_framed #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_RATE = 100_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx,
  input  logic       char_fifo_empty,
  input  logic [7:0] char_fifo_dout,
  output logic       char_fifo_rd_en,
  output logic       txd_tx,
  output logic       tx_busy
);

  localparam int BIT_CLKS = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CLKS - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  generate
    if (BIT_CLKS < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $fatal(1, "uart_tx_framed: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        bit_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  // Pop is decoded from the registered state so it lands in the same cycle
  // the FIFO head is latched, including the very first cycle after reset.
  always_comb begin
    char_fifo_rd_en = 1'b0;
    tx_busy         = 1'b0;
    if (!rst_clk_tx) begin
      char_fifo_rd_en = (state == S_IDLE) && !char_fifo_empty;
      tx_busy         = char_fifo_rd_en || (state != S_IDLE);
    end
  end

  always_ff @(posedge clk_tx) begin
    if (rst_clk_tx) begin
      state   <= S_IDLE;
      txd_tx  <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          txd_tx <= 1'b1;
          if (!char_fifo_empty) begin
            shreg   <= char_fifo_dout[DATA_BITS-1:0];
            par_bit <= (^char_fifo_dout[DATA_BITS-1:0]) ^ (PARITY == 2);
            bit_cnt <= BIT_LOAD;
            bit_idx <= '0;
            txd_tx  <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_cnt == '0) begin
            txd_tx  <= shreg[0];
            shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
            bit_cnt <= BIT_LOAD;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_LOAD;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                txd_tx <= par_bit;
                state  <= S_PARITY;
              end else begin
                txd_tx <= 1'b1;
                state  <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd_tx  <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_LOAD;
            bit_idx <= '0;
            txd_tx  <= 1'b1;
            state   <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_STOP: begin
          txd_tx <= 1'b1;
          // bit_idx counts stop bits so each one reuses the single-bit timer.
          if (bit_cnt == '0) begin
            bit_cnt <= BIT_LOAD;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          txd_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed: three instances (8N1, 7E2, 8O1) fed from
// modelled FIFOs; a monitor rebuilds each expected frame from the popped byte.
module tb_uart_tx_framed;

  localparam int BITC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_d = 1'b1;
  logic       empty [3];
  logic [7:0] dout  [3];
  logic       rd_en [3];
  logic       txd   [3];
  logic       busy  [3];

  logic [7:0] fifo_q [3][$];
  logic [7:0] exp_q  [3][$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int pops [3];
  int consumed [3];
  int busy_cnt [3];
  int pt_last [3];
  int pt_prev [3];
  int fcyc [3];
  int flen [3];
  logic [11:0] fbits [3];
  bit active [3];
  bit tog [3];
  bit phase [3];

  always #5 clk = ~clk;
  always @(posedge clk) rst_d <= rst;

  uart_tx_framed #(.BAUD_RATE(100_000), .CLOCK_RATE(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_8n1 (.clk_tx(clk), .rst_clk_tx(rst), .char_fifo_empty(empty[0]), .char_fifo_dout(dout[0]),
           .char_fifo_rd_en(rd_en[0]), .txd_tx(txd[0]), .tx_busy(busy[0]));
  uart_tx_framed #(.BAUD_RATE(100_000), .CLOCK_RATE(1_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
    u_7e2 (.clk_tx(clk), .rst_clk_tx(rst), .char_fifo_empty(empty[1]), .char_fifo_dout(dout[1]),
           .char_fifo_rd_en(rd_en[1]), .txd_tx(txd[1]), .tx_busy(busy[1]));
  uart_tx_framed #(.BAUD_RATE(100_000), .CLOCK_RATE(1_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_8o1 (.clk_tx(clk), .rst_clk_tx(rst), .char_fifo_empty(empty[2]), .char_fifo_dout(dout[2]),
           .char_fifo_rd_en(rd_en[2]), .txd_tx(txd[2]), .tx_busy(busy[2]));

  task automatic check(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity from popcount, stop 1s.
  function automatic void model_frame(input int i, input logic [7:0] b,
                                      output logic [11:0] bits, output int nbits);
    int db, par, sb, ones, k;
    db = (i == 1) ? 7 : 8;
    par = i;
    sb = (i == 1) ? 2 : 1;
    bits = '1;
    bits[0] = 1'b0;
    k = 1;
    ones = 0;
    for (int j = 0; j < db; j++) begin
      bits[k] = b[j];
      ones += int'(b[j]);
      k++;
    end
    if (par == 1) begin
      bits[k] = 1'((ones % 2) == 1);
      k++;
    end else if (par == 2) begin
      bits[k] = 1'((ones % 2) == 0);
      k++;
    end
    nbits = k + sb;
  endfunction

  // FIFO model: retire popped entries, then present head / empty (optionally
  // masked every other cycle with garbage on dout).
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      while (consumed[i] < pops[i]) begin
        if (fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
        consumed[i]++;
      end
      phase[i] = ~phase[i];
      empty[i] = (fifo_q[i].size() == 0) || (tog[i] && phase[i]);
      dout[i]  = empty[i] ? 8'($urandom) : fifo_q[i][0];
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    for (int i = 0; i < 3; i++) begin
      if (busy[i]) busy_cnt[i]++;
      if (rst) begin
        active[i] = 1'b0;
        check("rst_rd_en", i, int'(rd_en[i]), 0);
        check("rst_busy", i, int'(busy[i]), 0);
        if (rst_d) check("rst_txd", i, int'(txd[i]), 1);
      end else if (active[i]) begin
        check("txd_bit", i, int'(txd[i]), int'(fbits[i][fcyc[i] / BITC]));
        check("busy_frame", i, int'(busy[i]), 1);
        check("no_pop_in_frame", i, int'(rd_en[i]), 0);
        fcyc[i]++;
        if (fcyc[i] == flen[i] * BITC) active[i] = 1'b0;
      end else begin
        check("idle_txd", i, int'(txd[i]), 1);
        check("pop_when_ready", i, int'(rd_en[i]), int'(!empty[i]));
        check("busy_idle", i, int'(busy[i]), int'(!empty[i]));
        if (rd_en[i]) begin
          pops[i]++;
          pt_prev[i] = pt_last[i];
          pt_last[i] = cyc_n;
          check("scoreboard_has_entry", i, int'(exp_q[i].size() > 0), 1);
          if (exp_q[i].size() > 0) begin
            model_frame(i, exp_q[i].pop_front(), fbits[i], flen[i]);
            fcyc[i] = 0;
            active[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fifo_q[i].push_back(b);
    exp_q[i].push_back(b);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++)
      if (fifo_q[i].size() != 0 || active[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int limit);
    int t;
    t = 0;
    while (!all_idle() && t < limit) begin
      tick(1);
      t++;
    end
    check(name, 0, int'(all_idle()), 1);
  endtask

  initial begin
    int b0, p;
    for (int i = 0; i < 3; i++) begin
      empty[i] = 1'b1;
      dout[i] = '0;
    end
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(5);

    b0 = busy_cnt[0];
    push(0, 8'h55);
    push(1, 8'h87);
    push(2, 8'h00);
    push(2, 8'h01);
    wait_drain("drain_directed", 1000);
    check("busy_cycles_8n1", 0, busy_cnt[0] - b0, 101);

    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_drain("drain_b2b", 1000);
    check("b2b_pop_period", 0, pt_last[0] - pt_prev[0], 101);

    tog[0] = 1'b1;
    push(0, 8'hC3);
    push(0, 8'h5A);
    wait_drain("drain_toggle", 1000);
    tog[0] = 1'b0;

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 3; i++) begin
        tog[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) != 0) push(i, 8'($urandom));
      end
      tick($urandom_range(1, 80));
    end
    wait_drain("drain_random", 8000);
    for (int i = 0; i < 3; i++) tog[i] = 1'b0;
    tick(3);

    p = pops[0];
    push(0, 8'hB2);
    for (int t = 0; t < 100 && pops[0] == p; t++) tick(1);
    check("pop_before_reset", 0, pops[0] - p, 1);
    tick(44);
    rst = 1'b1;
    tick(1);
    #3;
    check("abort_txd", 0, int'(txd[0]), 1);
    check("abort_busy", 0, int'(busy[0]), 0);
    tick(2);
    rst = 1'b0;
    p = pops[0];
    tick(30);
    check("no_pop_after_abort", 0, pops[0] - p, 0);

    rst = 1'b1;
    push(0, 8'h3C);
    tick(3);
    p = pops[0];
    rst = 1'b0;
    tick(1);
    check("pop_on_release", 0, pops[0] - p, 1);
    wait_drain("drain_release", 1000);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bps.
REQ-002 SHALL have parameter CLOCK_RATE, default 100_000_000, clk_tx frequency in Hz.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal range 1..2.
REQ-006 SHALL have port clk_tx  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_clk_tx  input  1  reset, synchronous to clk_tx, active-high.
REQ-008 SHALL have port char_fifo_empty  input  1  empty flag of the first-word-fall-through char FIFO.
REQ-009 SHALL have port char_fifo_dout  input  8  FIFO head data; only bits [DATA_BITS-1:0] are transmitted.
REQ-010 SHALL have port char_fifo_rd_en  output  1  single-cycle pop strobe to the char FIFO.
REQ-011 SHALL have port txd_tx  output  1  serial output; idle level 1.
REQ-012 SHALL have port tx_busy  output  1  high from the pop cycle through the last stop-bit cycle.

Function
REQ-013 SHALL derive BIT_CLKS = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE clk_tx cycles per bit, computed at elaboration.
REQ-014 SHALL fail elaboration if BIT_CLKS < 2, DATA_BITS is outside 5..8, PARITY is outside 0..2, or STOP_BITS is outside 1..2.
REQ-015 SHALL implement the state machine IDLE -> START -> DATA -> PARITY (only when PARITY != 0) -> STOP -> IDLE.
REQ-016 SHALL time each bit with a down-counter loaded with BIT_CLKS-1 on state entry; a state advances on the cycle the counter reaches 0.
REQ-017 SHALL hold each bit on txd_tx for exactly BIT_CLKS cycles; STOP lasts STOP_BITS*BIT_CLKS cycles.
REQ-018 SHALL, in IDLE with char_fifo_empty = 0, assert char_fifo_rd_en for exactly one cycle, latch char_fifo_dout in that cycle, and enter START on the next cycle.
REQ-019 SHALL drive txd_tx low on the first START cycle, one cycle after the char_fifo_rd_en pulse; txd_tx is registered and glitch-free.
REQ-020 SHALL send DATA_BITS data bits LSB first, using a bit index counter that runs 0..DATA_BITS-1.
REQ-021 SHALL send the parity bit as the XOR of the transmitted data bits (PARITY = 1), or its complement (PARITY = 2).
REQ-022 SHALL drive txd_tx high in STOP and IDLE.
REQ-023 SHALL spend at least one IDLE cycle between frames, so back-to-back frame period = frame_bits*BIT_CLKS + 1 cycles, where frame_bits = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
REQ-024 SHALL never assert char_fifo_rd_en when char_fifo_empty = 1 or when state != IDLE.
REQ-025 SHALL ignore char_fifo_empty and char_fifo_dout changes during a frame; the latched byte is not altered.
REQ-026 SHALL assert tx_busy combinationally with char_fifo_rd_en and deassert it on the first IDLE cycle after STOP.

Reset
REQ-027 SHALL, while rst_clk_tx = 1, force state = IDLE, txd_tx = 1, char_fifo_rd_en = 0, tx_busy = 0, and clear all counters and the shift register.
REQ-028 SHALL, on reset asserted mid-frame, abort the frame: txd_tx = 1 from the next clock edge, with no further pop and no completion of the partial frame.
REQ-029 SHALL, on the first cycle after reset release with char_fifo_empty = 0, pop in that cycle.

Verification (CLOCK_RATE=1_000_000, BAUD_RATE=100_000 -> BIT_CLKS=10)
REQ-030 SHALL verify 8N1 with byte 0x55: one rd_en pulse; txd low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles; tx_busy high for 101 cycles.
REQ-031 SHALL verify 7E2 with byte 0x87: data 1,1,1,0,0,0,0; parity bit 1; stop high for 20 cycles; bit 7 of the byte is not transmitted.
REQ-032 SHALL verify 8O1 with byte 0x00: parity bit 1; and with 0x01: parity bit 0.
REQ-033 SHALL verify back-to-back 0xA5 then 0x3C with the FIFO never empty: rd_en pulses 101 cycles apart (8N1); txd high exactly 1 idle cycle between frames.
REQ-034 SHALL verify reset asserted in the 4th data bit: txd = 1 and tx_busy = 0 the next cycle; after release with empty = 1, no rd_en and txd stays 1.
REQ-035 SHALL verify char_fifo_empty toggling every cycle during a frame: no rd_en pulse occurs until IDLE, and the transmitted bits match the byte latched at the pop.
